// File: rtl/aurora_tx_framer_64b66b.sv
// 64b/66b TX block framer feeding the 66->32 gearbox: one block per data_next request.
// Define FRAMER_CC_INSERT_EN to enable periodic clock-compensation (CC) burst insertion.
module aurora_tx_framer_64b66b #(
  parameter int unsigned INIT_IDLES = 16,
  parameter int unsigned CC_PERIOD  = 5000,
  parameter int unsigned CC_LEN     = 3,
  parameter logic [57:0] SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF,
  parameter logic [63:0] IDLE_WORD  = 64'h7800_0000_0000_0000,
  parameter logic [63:0] CC_WORD    = 64'h7880_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        data_next,
  output logic [65:0] data66,
  output logic [1:0]  tx_state,
  output logic        cc_active
);

  typedef enum logic [1:0] {StInit = 2'd0, StRun = 2'd1, StCc = 2'd2} state_e;

  localparam int unsigned      InitW    = $clog2(INIT_IDLES + 1);
  localparam logic [InitW-1:0] InitLast = InitW'(INIT_IDLES - 1);
  localparam logic [65:0]      IdleBlk  = {2'b10, IDLE_WORD};
  localparam logic [65:0]      CcBlk    = {2'b10, CC_WORD};

  state_e           state_q, state_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;
  logic [57:0]      scr_q, scr_d;
  logic [65:0]      data_q, data_d;
  logic [63:0]      sc;
  logic             cc_due;

  // Parallel x^58+x^39+1 scrambler over one 64-bit payload; low bits resolve from prior state.
  function automatic logic [63:0] scramble(input logic [63:0] d, input logic [57:0] s);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 39; i++) o[i] = d[i] ^ s[i + 19] ^ s[i];
    for (int i = 39; i < 58; i++) o[i] = d[i] ^ o[i - 39] ^ s[i];
    for (int i = 58; i < 64; i++) o[i] = d[i] ^ o[i - 39] ^ o[i - 58];
    return o;
  endfunction

  assign sc = scramble(s_data, scr_q);

`ifdef FRAMER_CC_INSERT_EN
  localparam int unsigned     BlkW    = $clog2(CC_PERIOD);
  localparam int unsigned     CcW     = $clog2(CC_LEN + 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(CC_PERIOD - 1);
  localparam logic [CcW-1:0]  CcLast  = CcW'(CC_LEN - 1);

  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic [CcW-1:0]  cc_cnt_q, cc_cnt_d;
  logic            cc_q, cc_d;

  assign cc_due    = (blk_cnt_q == BlkLast);
  assign cc_active = cc_q;
`else
  assign cc_due    = 1'b0;
  assign cc_active = 1'b0;
`endif

  assign s_ready  = data_next & (state_q == StRun) & ~cc_due;
  assign data66   = data_q;
  assign tx_state = state_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    scr_d      = scr_q;
    data_d     = data_q;
`ifdef FRAMER_CC_INSERT_EN
    blk_cnt_d  = blk_cnt_q;
    cc_cnt_d   = cc_cnt_q;
    cc_d       = cc_q;
`endif
    if (data_next) begin
      case (state_q)
        StInit: begin
          data_d     = IdleBlk;
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == InitLast) begin
            state_d    = StRun;
            init_cnt_d = '0;
          end
        end
        StRun: begin
`ifdef FRAMER_CC_INSERT_EN
          cc_d      = cc_due;
          blk_cnt_d = cc_due ? '0 : blk_cnt_q + 1'b1;
`endif
          if (cc_due) begin
            data_d = CcBlk;
`ifdef FRAMER_CC_INSERT_EN
            if (CC_LEN > 1) begin
              state_d  = StCc;
              cc_cnt_d = CcW'(1);
            end
`endif
          end else if (s_valid) begin
            // Only data payloads advance the scrambler.
            data_d = {2'b01, sc};
            scr_d  = sc[63:6];
          end else begin
            data_d = IdleBlk;
          end
        end
        StCc: begin
          data_d = CcBlk;
`ifdef FRAMER_CC_INSERT_EN
          cc_d = 1'b1;
          if (cc_cnt_q == CcLast) begin
            state_d  = StRun;
            cc_cnt_d = '0;
          end else begin
            cc_cnt_d = cc_cnt_q + 1'b1;
          end
`else
          state_d = StRun;
`endif
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      scr_q      <= SCR_SEED;
      data_q     <= IdleBlk;
`ifdef FRAMER_CC_INSERT_EN
      blk_cnt_q  <= '0;
      cc_cnt_q   <= '0;
      cc_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      scr_q      <= scr_d;
      data_q     <= data_d;
`ifdef FRAMER_CC_INSERT_EN
      blk_cnt_q  <= blk_cnt_d;
      cc_cnt_q   <= cc_cnt_d;
      cc_q       <= cc_d;
`endif
    end
  end

endmodule

// File: tb/tb_aurora_tx_framer_64b66b.sv
// Directed bench for aurora_tx_framer_64b66b: INIT, scrambler vectors, idle/CC interleave, reset.
module tb_aurora_tx_framer_64b66b;

  localparam int unsigned P_INIT = 16;
  localparam int unsigned P_PER  = 8;
  localparam int unsigned P_LEN  = 3;
  localparam logic [57:0] P_SEED = 58'h0;
  localparam logic [65:0] IDLE_BLK = {2'b10, 64'h7800_0000_0000_0000};
  localparam logic [65:0] CC_BLK   = {2'b10, 64'h7880_0000_0000_0000};

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        data_next;
  logic [65:0] data66;
  logic [1:0]  tx_state;
  logic        cc_active;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [1:0]  m_state;
  int          m_init, m_blk, m_cc;
  logic [57:0] m_scr;

  aurora_tx_framer_64b66b #(
    .INIT_IDLES(P_INIT),
    .CC_PERIOD (P_PER),
    .CC_LEN    (P_LEN),
    .SCR_SEED  (P_SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_next(data_next),
    .data66   (data66),
    .tx_state (tx_state),
    .cc_active(cc_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serial form of the scrambler: x[0..57] = state, x[58+i] = scrambled bit i.
  function automatic logic [121:0] mdl_scr(input logic [63:0] d, input logic [57:0] s);
    logic [121:0] x;
    x = '0;
    x[57:0] = s;
    for (int i = 0; i < 64; i++) x[58 + i] = d[i] ^ x[19 + i] ^ x[i];
    return x;
  endfunction

  task automatic mdl_reset();
    m_state = 2'd0;
    m_init  = 0;
    m_blk   = 0;
    m_cc    = 0;
    m_scr   = P_SEED;
  endtask

  // One gearbox request; predicts and checks s_ready, the emitted block and the new state.
  task automatic pulse(input logic v, input logic [63:0] d, input bit gap, output bit acc);
    logic [65:0]  e;
    logic [121:0] x;
    logic         erdy, due;
    @(negedge clk);
    s_valid   = v;
    s_data    = d;
    data_next = 1'b1;
    #1;
`ifdef FRAMER_CC_INSERT_EN
    due = (m_blk == int'(P_PER) - 1);
`else
    due = 1'b0;
`endif
    erdy = (m_state == 2'd1) && !due;
    acc  = erdy && v;
    check("s_ready", {65'b0, s_ready}, {65'b0, erdy});
    check("tx_state_pre", {64'b0, tx_state}, {64'b0, m_state});
    e = IDLE_BLK;
    case (m_state)
      2'd0: begin
        m_init++;
        if (m_init == int'(P_INIT)) begin
          m_state = 2'd1;
          m_init  = 0;
        end
      end
      2'd1: begin
        if (due) begin
          e       = CC_BLK;
          m_blk   = 0;
          m_cc    = 1;
          m_state = 2'd2;
        end else begin
          m_blk++;
          if (v) begin
            x     = mdl_scr(d, m_scr);
            e     = {2'b01, x[121:58]};
            m_scr = x[121:64];
          end
        end
      end
      default: begin
        e = CC_BLK;
        m_cc++;
        if (m_cc == int'(P_LEN)) begin
          m_state = 2'd1;
          m_cc    = 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
    data_next = 1'b0;
    check("data66", data66, e);
    check("cc_active", {65'b0, cc_active}, {65'b0, (e == CC_BLK)});
    check("tx_state", {64'b0, tx_state}, {64'b0, m_state});
    if (gap) @(posedge clk);
  endtask

  initial begin
    bit          acc;
    int          w, cc_n, dat_n, bad, n_long;
    logic [63:0] base;

    rst       = 1'b1;
    data_next = 1'b1;
    s_valid   = 1'b1;
    s_data    = 64'h0;
    mdl_reset();
    #12;
    check("rst_data66", data66, IDLE_BLK);
    check("rst_tx_state", {64'b0, tx_state}, 66'd0);
    check("rst_cc_active", {65'b0, cc_active}, 66'd0);
    check("rst_s_ready", {65'b0, s_ready}, 66'd0);
    @(negedge clk);
    rst       = 1'b0;
    data_next = 1'b0;

    // INIT with data_next every 2nd cycle and s_valid held high
    for (int k = 0; k < int'(P_INIT); k++) pulse(1'b1, 64'h0, 1'b1, acc);
    pulse(1'b1, 64'h0, 1'b1, acc);
    check("first_data_zero", data66, 66'h1_0000_0000_0000_0000);
    check("first_data_acc", {65'b0, acc}, 66'd1);
    pulse(1'b1, 64'h1, 1'b0, acc);
    check("scr_one", data66, 66'h1_0400_0080_0000_0001);

    // Idle blocks in RUN leave the scrambler untouched
    for (int k = 0; k < 3; k++) pulse(1'b0, 64'hDEAD_BEEF_0000_0000, 1'b0, acc);

    // Continuous stream across CC bursts; the source holds a word until it is accepted
    base  = 64'hA5A5_0000_0000_0000;
    w     = 0;
    cc_n  = 0;
    dat_n = 0;
    for (int k = 0; k < 30; k++) begin
      pulse(1'b1, base + 64'(w), 1'b0, acc);
      if (acc) w++;
      if (data66 == CC_BLK) cc_n++;
      else if (data66[65:64] == 2'b01) dat_n++;
    end
`ifdef FRAMER_CC_INSERT_EN
    check("stream_cc_blocks", 66'(cc_n), 66'd9);
    check("stream_data_blocks", 66'(dat_n), 66'd21);
    check("stream_words", 66'(w), 66'd21);
`else
    check("stream_cc_blocks", 66'(cc_n), 66'd0);
    check("stream_data_blocks", 66'(dat_n), 66'd30);
    check("stream_words", 66'(w), 66'd30);
`endif

    // Reaches the 2nd CC block of the next burst when CC insertion is built in
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, base + 64'(w), 1'b0, acc);
      if (acc) w++;
    end
`ifdef FRAMER_CC_INSERT_EN
    check("pre_rst_in_cc", {64'b0, tx_state}, 66'd2);
`endif
    #2;
    rst       = 1'b1;
    data_next = 1'b1;
    #1;
    check("arst_data66", data66, IDLE_BLK);
    check("arst_tx_state", {64'b0, tx_state}, 66'd0);
    check("arst_cc_active", {65'b0, cc_active}, 66'd0);
    check("arst_s_ready", {65'b0, s_ready}, 66'd0);
    @(negedge clk);
    rst       = 1'b0;
    data_next = 1'b0;
    mdl_reset();
    for (int k = 0; k < int'(P_INIT); k++) pulse(1'b1, 64'h1, 1'b0, acc);
    pulse(1'b1, 64'h1, 1'b0, acc);
    check("reinit_first_data", data66, 66'h1_0400_0080_0000_0001);

    // Long run with mixed valid
`ifdef FRAMER_CC_INSERT_EN
    n_long = 300;
`else
    n_long = 20000;
`endif
    bad = 0;
    w   = 0;
    for (int k = 0; k < n_long; k++) begin
      pulse((k % 3) != 0, {32'(w), ~32'(w)}, 1'b0, acc);
      if (acc) w++;
      if (cc_active || tx_state == 2'd2) bad++;
    end
`ifndef FRAMER_CC_INSERT_EN
    check("no_cc_seen", 66'(bad), 66'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
